// File: rtl/camera_rd_scene_sync.sv
// Scene-synchronised SDRAM read selector for a camera pipeline.
// Queues scene-switch requests, applies them at frame end (or immediately),
// flushes the SDRAM read path for a fixed number of cycles on each switch and
// only re-enables reads once the next frame start has been seen.
module camera_rd_scene_sync #(
    parameter int unsigned NUM_SCENE    = 4,
    parameter int unsigned SOF_H        = 100,
    parameter int unsigned SOF_V        = 10,
    parameter int unsigned EOF_H        = 1340,
    parameter int unsigned EOF_V        = 804,
    parameter int unsigned RST_CYCLES   = 4,
    parameter bit          DEFER_SWITCH = 1'b1,
    parameter int unsigned SW           = (NUM_SCENE > 2) ? $clog2(NUM_SCENE) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [11:0]          hcnt,
    input  logic [11:0]          vcnt,
    input  logic [NUM_SCENE-1:0] scene_req,
    input  logic [NUM_SCENE-1:0] scene_rden,
    output logic                 sdram_rst_n,
    output logic                 sdram_rden,
    output logic [SW-1:0]        active_scene,
    output logic                 pending_vld,
    output logic                 running
);

    typedef enum logic [1:0] {
        StWaitSof = 2'd0,
        StRun     = 2'd1,
        StFlush   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          sof_p_q, eof_p_q;
    logic [SW-1:0] active_q, active_d;
    logic          pending_vld_q, pending_vld_d;
    logic [SW-1:0] pending_idx_q, pending_idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          sdram_rst_n_q, sdram_rst_n_d;

    logic          req_vld;
    logic [SW-1:0] req_idx;
    logic          apply_cond;
    logic          flush_last;
    logic          apply;
    logic          rden_sel;

    // Frame start/end markers, registered one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_p_q <= 1'b0;
            eof_p_q <= 1'b0;
        end else begin
            sof_p_q <= (hcnt == 12'(SOF_H)) && (vcnt == 12'(SOF_V));
            eof_p_q <= (hcnt == 12'(EOF_H)) && (vcnt == 12'(EOF_V));
        end
    end

    // Request decode: lowest set bit wins
    always_comb begin
        req_vld = |scene_req;
        req_idx = '0;
        for (int i = int'(NUM_SCENE) - 1; i >= 0; i--) begin
            if (scene_req[i]) begin
                req_idx = SW'(i);
            end
        end
    end

    // A switch may only land outside FLUSH or on its final cycle
    always_comb begin
        apply_cond = pending_vld_q && (DEFER_SWITCH ? eof_p_q : 1'b1);
        flush_last = (state_q == StFlush) && (cnt_q == 8'd1);
        apply      = apply_cond && ((state_q != StFlush) || flush_last);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWaitSof;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a pending switch has priority over frame start
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitSof: begin
                if (apply) begin
                    state_d = StFlush;
                end else if (sof_p_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (apply) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (flush_last) begin
                    state_d = apply ? StFlush : StWaitSof;
                end
            end
            default: state_d = StWaitSof;
        endcase
    end

    // FSM outputs; out-of-range scene index selects nothing
    always_comb begin
        running  = (state_q == StRun);
        rden_sel = 1'b0;
        for (int i = 0; i < int'(NUM_SCENE); i++) begin
            if (active_q == SW'(i)) begin
                rden_sel = scene_rden[i];
            end
        end
        sdram_rden = running && rden_sel;
    end

    // Scene, pending request, flush counter and flush output next state
    always_comb begin
        active_d      = active_q;
        pending_vld_d = pending_vld_q;
        pending_idx_d = pending_idx_q;
        cnt_d         = cnt_q;

        if (apply) begin
            active_d      = pending_idx_q;
            pending_vld_d = 1'b0;
            cnt_d         = 8'(RST_CYCLES);
        end else if (state_q == StFlush) begin
            cnt_d = cnt_q - 8'd1;
        end

        // New request is judged against the scene that will be active next,
        // so a request landing with a switch becomes the next pending entry.
        if (req_vld) begin
            if (req_idx == active_d) begin
                pending_vld_d = 1'b0;
            end else begin
                pending_vld_d = 1'b1;
                pending_idx_d = req_idx;
            end
        end

        sdram_rst_n_d = (state_d != StFlush);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= '0;
            pending_vld_q <= 1'b0;
            pending_idx_q <= '0;
            cnt_q         <= 8'd0;
            sdram_rst_n_q <= 1'b1;
        end else begin
            active_q      <= active_d;
            pending_vld_q <= pending_vld_d;
            pending_idx_q <= pending_idx_d;
            cnt_q         <= cnt_d;
            sdram_rst_n_q <= sdram_rst_n_d;
        end
    end

    assign sdram_rst_n  = sdram_rst_n_q;
    assign active_scene = active_q;
    assign pending_vld  = pending_vld_q;

endmodule

// File: tb/tb_camera_rd_scene_sync.sv
// Bench for camera_rd_scene_sync: one deferred-switch and one immediate-switch
// instance, each tracked by a frame-level behavioural model, plus directed
// literal checks of the key scenarios.
module tb_camera_rd_scene_sync;

    localparam int RST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hcnt, vcnt;
    logic [3:0]  req_a, req_b, rden;

    logic       srst_a, srden_a, pvld_a, run_a;
    logic [1:0] act_a;
    logic       srst_b, srden_b, pvld_b, run_b;
    logic [1:0] act_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    camera_rd_scene_sync dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .scene_req    (req_a),
        .scene_rden   (rden),
        .sdram_rst_n  (srst_a),
        .sdram_rden   (srden_a),
        .active_scene (act_a),
        .pending_vld  (pvld_a),
        .running      (run_a)
    );

    camera_rd_scene_sync #(
        .DEFER_SWITCH (1'b0)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .scene_req    (req_b),
        .scene_rden   (rden),
        .sdram_rst_n  (srst_b),
        .sdram_rden   (srden_b),
        .active_scene (act_b),
        .pending_vld  (pvld_b),
        .running      (run_b)
    );

    // Frame-level model: flush = flush cycles still to run (incl. current)
    typedef struct {
        logic [1:0] active;
        logic       pvld;
        logic [1:0] pidx;
        int         flush;
        logic       run;
        logic       sof;
        logic       eof;
    } model_t;

    model_t ma, mb;

    function automatic model_t idle_model();
        model_t m;
        m.active = 2'd0;
        m.pvld   = 1'b0;
        m.pidx   = 2'd0;
        m.flush  = 0;
        m.run    = 1'b0;
        m.sof    = 1'b0;
        m.eof    = 1'b0;
        return m;
    endfunction

    function automatic model_t step(input model_t s, input logic defer,
                                    input logic [11:0] h, input logic [11:0] v,
                                    input logic [3:0] req);
        model_t     n;
        logic       sw;
        logic [1:0] ridx;
        n    = s;
        ridx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) ridx = 2'(i);
        end
        sw = s.pvld && (!defer || s.eof) && (s.flush <= 1);
        if (sw) begin
            n.active = s.pidx;
            n.pvld   = 1'b0;
            n.flush  = RST;
            n.run    = 1'b0;
        end else if (s.flush > 0) begin
            n.flush = s.flush - 1;
        end else if (!s.run && s.sof) begin
            n.run = 1'b1;
        end
        if (req != 4'd0) begin
            if (ridx == n.active) begin
                n.pvld = 1'b0;
            end else begin
                n.pvld = 1'b1;
                n.pidx = ridx;
            end
        end
        n.sof = (h == 12'd100) && (v == 12'd10);
        n.eof = (h == 12'd1340) && (v == 12'd804);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= idle_model();
            mb <= idle_model();
        end else begin
            ma <= step(ma, 1'b1, hcnt, vcnt, req_a);
            mb <= step(mb, 1'b0, hcnt, vcnt, req_b);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("a_sdram_rst_n", 32'(srst_a), 32'(ma.flush == 0));
            chk("a_running", 32'(run_a), 32'(ma.run));
            chk("a_active", 32'(act_a), 32'(ma.active));
            chk("a_pending", 32'(pvld_a), 32'(ma.pvld));
            chk("a_rden", 32'(srden_a), 32'(ma.run ? rden[ma.active] : 1'b0));
            chk("b_sdram_rst_n", 32'(srst_b), 32'(mb.flush == 0));
            chk("b_running", 32'(run_b), 32'(mb.run));
            chk("b_active", 32'(act_b), 32'(mb.active));
            chk("b_pending", 32'(pvld_b), 32'(mb.pvld));
            chk("b_rden", 32'(srden_b), 32'(mb.run ? rden[mb.active] : 1'b0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] tr_a;
        logic [8:0] tr_b;

        rst_n = 1'b0;
        hcnt  = 12'd0;
        vcnt  = 12'd0;
        req_a = 4'd0;
        req_b = 4'd0;
        rden  = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_sdram_rst_n", 32'(srst_a), 32'd1);
        chk("reset_running", 32'(run_a), 32'd0);
        chk("reset_active", 32'(act_a), 32'd0);
        chk("reset_pending", 32'(pvld_a), 32'd0);
        chk("reset_rden", 32'(srden_a), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Start of frame brings both instances into RUN
        rden = 4'b0101;
        #1;
        chk("pre_sof_rden", 32'(srden_a), 32'd0);
        hcnt = 12'd100; vcnt = 12'd10;
        @(negedge clk);
        hcnt = 12'd0; vcnt = 12'd0;
        chk("sof_plus1_running", 32'(run_a), 32'd0);
        @(negedge clk);
        chk("sof_plus2_running", 32'(run_a), 32'd1);
        chk("sof_plus2_rden", 32'(srden_a), 32'd1);
        chk("sof_plus2_running_b", 32'(run_b), 32'd1);

        // Lowest index wins, then a request for the active scene cancels
        req_a = 4'b1010;
        @(negedge clk);
        req_a = 4'b0001;
        chk("multi_hot_pending", 32'(pvld_a), 32'd1);
        chk("multi_hot_idx", 32'(dut_a.pending_idx_q), 32'd1);
        @(negedge clk);
        req_a = 4'd0;
        chk("cancel_pending", 32'(pvld_a), 32'd0);
        hcnt = 12'd1340; vcnt = 12'd804;
        @(negedge clk);
        hcnt = 12'd0; vcnt = 12'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("cancel_no_flush", 32'(srst_a), 32'd1);
            chk("cancel_still_run", 32'(run_a), 32'd1);
        end

        // Deferred switch to scene 2 at frame end
        req_a = 4'b0100;
        @(negedge clk);
        req_a = 4'd0;
        chk("defer_pending", 32'(pvld_a), 32'd1);
        chk("defer_active_held", 32'(act_a), 32'd0);
        hcnt = 12'd1340; vcnt = 12'd804;
        @(negedge clk);
        hcnt = 12'd0; vcnt = 12'd0;
        chk("eof_plus1_no_flush", 32'(srst_a), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tr_a[k] = srst_a;
            if (k == 0) begin
                chk("switch_active", 32'(act_a), 32'd2);
                chk("switch_running", 32'(run_a), 32'd0);
            end
        end
        chk("flush_4_cycles", 32'(tr_a), 32'(6'b110000));
        chk("post_flush_wait_sof", 32'(run_a), 32'd0);
        chk("post_flush_rden", 32'(srden_a), 32'd0);
        hcnt = 12'd100; vcnt = 12'd10;
        @(negedge clk);
        hcnt = 12'd0; vcnt = 12'd0;
        chk("resume_plus1_rden", 32'(srden_a), 32'd0);
        @(negedge clk);
        chk("resume_running", 32'(run_a), 32'd1);
        chk("resume_rden_scene2", 32'(srden_a), 32'd1);

        // Immediate switch with a second request during the flush
        req_b = 4'b0100;
        @(negedge clk);
        req_b = 4'd0;
        chk("imm_pending", 32'(pvld_b), 32'd1);
        chk("imm_not_yet_flushing", 32'(srst_b), 32'd1);
        @(negedge clk);
        chk("imm_active", 32'(act_b), 32'd2);
        tr_b[0] = srst_b;
        req_b = 4'b1000;
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            req_b = 4'd0;
            tr_b[k] = srst_b;
        end
        chk("back_to_back_8_low", 32'(tr_b), 32'(9'b100000000));
        chk("back_to_back_active", 32'(act_b), 32'd3);
        chk("back_to_back_pending", 32'(pvld_b), 32'd0);

        // Reset in the second flush cycle discards the queued switch
        req_a = 4'b0010;
        @(negedge clk);
        req_a = 4'd0;
        hcnt = 12'd1340; vcnt = 12'd804;
        @(negedge clk);
        hcnt = 12'd0; vcnt = 12'd0;
        @(negedge clk);
        chk("rst_test_flush1", 32'(srst_a), 32'd0);
        chk("rst_test_active1", 32'(act_a), 32'd1);
        req_a = 4'b1000;
        @(negedge clk);
        req_a = 4'd0;
        chk("rst_test_flush2", 32'(srst_a), 32'd0);
        chk("rst_test_pending", 32'(pvld_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sdram_rst_n", 32'(srst_a), 32'd1);
        chk("async_rst_active", 32'(act_a), 32'd0);
        chk("async_rst_pending", 32'(pvld_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        hcnt = 12'd100; vcnt = 12'd10;
        @(negedge clk);
        hcnt = 12'd0; vcnt = 12'd0;
        @(negedge clk);
        chk("post_rst_running", 32'(run_a), 32'd1);
        chk("post_rst_rden", 32'(srden_a), 32'd1);
        chk("post_rst_active", 32'(act_a), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/camera_rd_scene_sync.md
CAMERA_RD_SCENE_SYNC -- requirements
Module: camera_rd_scene_sync

Interface
REQ-001 Parameter NUM_SCENE, default 4, number of scenes (2..16); each scene has its own SDRAM read-enable source.
REQ-002 Parameter SOF_H / SOF_V, default 100 / 10, hcnt/vcnt position that marks the frame start.
REQ-003 Parameter EOF_H / EOF_V, default 1340 / 804, hcnt/vcnt position that marks the frame end.
REQ-004 Parameter RST_CYCLES, default 4, length of the sdram_rst_n low pulse on a scene switch (1..255).
REQ-005 Parameter DEFER_SWITCH, default 1: 1 applies a switch at the frame end; 0 applies it immediately.
REQ-006 Parameter SW = max(1, clog2(NUM_SCENE)), derived index width.
REQ-007 clk  in  1  system clock; all logic on the rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 hcnt  in  12  horizontal pixel counter.
REQ-010 vcnt  in  12  vertical line counter.
REQ-011 scene_req  in  NUM_SCENE  scene request flags; bit i requests scene i; may be multi-hot.
REQ-012 scene_rden  in  NUM_SCENE  per-scene SDRAM read enable.
REQ-013 sdram_rst_n  out  1  registered active-low SDRAM FIFO/buffer flush.
REQ-014 sdram_rden  out  1  muxed read enable for the active scene.
REQ-015 active_scene  out  SW  index of the current scene.
REQ-016 pending_vld  out  1  a switch is queued and not yet applied.
REQ-017 running  out  1  high in RUN state.

Function
REQ-018 sof_p / eof_p SHALL be registered one-cycle pulses, high the cycle after (hcnt,vcnt) equals (SOF_H,SOF_V) / (EOF_H,EOF_V).
REQ-019 Request decode: lowest set index of scene_req wins; scene_req = 0 is no request.
REQ-020 A decoded request equal to active_scene with pending_vld = 0 SHALL be ignored.
REQ-021 A decoded request equal to active_scene with pending_vld = 1 SHALL cancel the pending switch (pending_vld <= 0).
REQ-022 Any other request SHALL load pending_idx and set pending_vld; a newer request overwrites an older pending one.
REQ-023 FSM states: WAIT_SOF, RUN, FLUSH.
REQ-024 Apply condition: pending_vld & (DEFER_SWITCH ? eof_p : 1), evaluated in WAIT_SOF or RUN. It SHALL load active_scene <= pending_idx, clear pending_vld, enter FLUSH, and load the counter with RST_CYCLES.
REQ-025 In FLUSH, sdram_rst_n SHALL be 0 for exactly RST_CYCLES cycles, starting the cycle after the apply condition.
REQ-026 At FLUSH end, the FSM SHALL enter FLUSH again if the apply condition holds in that cycle; otherwise it SHALL enter WAIT_SOF.
REQ-027 WAIT_SOF -> RUN the cycle after sof_p = 1, unless the apply condition holds in the same cycle (the switch has priority).
REQ-028 In RUN, sdram_rden = scene_rden[active_scene] combinationally; in any other state it SHALL be 0.
REQ-029 Requests arriving during FLUSH SHALL be latched per REQ-020..022 and never dropped.
REQ-030 The request and apply conditions in the same cycle: the switch applies the previously pending index; the new request becomes pending.
REQ-031 An active_scene index >= NUM_SCENE is unreachable; sdram_rden SHALL be forced to 0 if it is ever reached.

Reset
REQ-032 During reset: state = WAIT_SOF, active_scene = 0, pending_vld = 0, sdram_rst_n = 1, sdram_rden = 0, running = 0, sof_p = eof_p = 0, counter = 0.
REQ-033 Reset assertion mid-FLUSH SHALL immediately return sdram_rst_n to 1 and discard the pending switch.

Verification (NUM_SCENE=4, RST_CYCLES=4, defaults)
REQ-034 Release reset, drive hcnt=100,vcnt=10 for one cycle, then scene_rden[0]=1 -> running=1 two cycles after the match; sdram_rden=1; before the match, sdram_rden=0.
REQ-035 In RUN, pulse scene_req=4'b0100 -> pending_vld=1; at eof_p: active_scene=2, sdram_rst_n low for exactly 4 cycles, then WAIT_SOF; sdram_rden follows scene_rden[2] only after the next sof_p.
REQ-036 scene_req=4'b1010 with active_scene=0 -> pending_idx=1 (lowest index wins); a following scene_req=4'b0001 before EOF -> pending_vld=0, no flush at EOF.
REQ-037 DEFER_SWITCH=0, request scene 3 during FLUSH -> a second 4-cycle flush back-to-back; active_scene=3; sdram_rst_n low for 8 consecutive cycles.
REQ-038 Assert rst_n=0 in the 2nd FLUSH cycle -> sdram_rst_n=1 asynchronously, active_scene=0, pending_vld=0; a normal SOF start follows release.
